// File: rtl/mips_muldiv_ctrl.sv
// Iterative MIPS multiply/divide sequencer with the HI/LO register pair.
// One shift-add or restoring-divide step per clock on magnitudes; signs are applied in the FIX state.
module mips_muldiv_ctrl #(
  parameter int ITER = 32
) (
  input  logic        clk,
  input  logic        rst_b,
  input  logic        start,
  input  logic [1:0]  op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        mthi,
  input  logic        mtlo,
  input  logic        hilo_rd,
  output logic [31:0] hi,
  output logic [31:0] lo,
  output logic        busy,
  output logic        done,
  output logic        stall
);

  localparam int CW = $clog2(ITER);

  typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [63:0]     p_q, p_d;
  logic [31:0]     opnd_q, opnd_d;
  logic [31:0]     hi_q, hi_d, lo_q, lo_d;
  logic            div_q, div_d;
  logic            neg_q, neg_d;
  logic            rneg_q, rneg_d;
  logic            dz_q, dz_d;
  logic            done_q, done_d;

  logic            rs_neg, rt_neg;
  logic [31:0]     rs_mag, rt_mag;
  logic [32:0]     mul_sum;
  logic [63:0]     mul_step;
  logic [64:0]     div_sh;
  logic [32:0]     div_diff;
  logic            div_ge;
  logic [63:0]     div_step;
  logic [63:0]     prod_fix;

  // Signed ops work on 32-bit unsigned magnitudes, so |0x80000000| = 2^31 fits.
  assign rs_neg = ~op[0] & rs_val[31];
  assign rt_neg = ~op[0] & rt_val[31];
  assign rs_mag = rs_neg ? -rs_val : rs_val;
  assign rt_mag = rt_neg ? -rt_val : rt_val;

  // p_q holds {accumulator, multiplier} for MULT and {remainder, quotient} for DIV.
  assign mul_sum  = {1'b0, p_q[63:32]} + (p_q[0] ? {1'b0, opnd_q} : 33'd0);
  assign mul_step = {mul_sum, p_q[31:1]};
  assign div_sh   = {p_q, 1'b0};
  assign div_ge   = div_sh[64:32] >= {1'b0, opnd_q};
  assign div_diff = div_sh[64:32] - {1'b0, opnd_q};
  assign div_step = div_ge ? {div_diff[31:0], p_q[30:0], 1'b1}
                           : {p_q[62:31], p_q[30:0], 1'b0};
  assign prod_fix = neg_q ? -p_q : p_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    opnd_d  = opnd_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    div_d   = div_q;
    neg_d   = neg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          cnt_d   = '0;
          div_d   = op[1];
          opnd_d  = op[1] ? rt_mag : rs_mag;
          p_d     = {32'd0, op[1] ? rs_mag : rt_mag};
          neg_d   = rs_neg ^ rt_neg;
          rneg_d  = rs_neg;
          dz_d    = op[1] & (rt_val == 32'd0);
        end else begin
          if (mthi) hi_d = rs_val;
          if (mtlo) lo_d = rs_val;
        end
      end
      RUN: begin
        p_d   = div_q ? div_step : mul_step;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(ITER - 1)) state_d = FIX;
      end
      FIX: begin
        state_d = IDLE;
        done_d  = 1'b1;
        if (div_q) begin
          // With a zero divisor the remainder path leaves |rs| behind, so the sign restore yields rs_val.
          lo_d = dz_q ? 32'hFFFF_FFFF : (neg_q ? -p_q[31:0] : p_q[31:0]);
          hi_d = rneg_q ? -p_q[63:32] : p_q[63:32];
        end else begin
          hi_d = prod_fix[63:32];
          lo_d = prod_fix[31:0];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_b) begin
    if (!rst_b) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      p_q     <= '0;
      opnd_q  <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      div_q   <= 1'b0;
      neg_q   <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      opnd_q  <= opnd_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div_q   <= div_d;
      neg_q   <= neg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
      done_q  <= done_d;
    end
  end

  assign hi    = hi_q;
  assign lo    = lo_q;
  assign busy  = (state_q != IDLE);
  assign done  = done_q;
  assign stall = busy & (start | mthi | mtlo | hilo_rd);

endmodule

// File: tb/tb_mips_muldiv_ctrl.sv
// Scoreboard bench for mips_muldiv_ctrl: expected {hi,lo} queued at issue, checked at done.
module tb_mips_muldiv_ctrl;

  logic        clk = 1'b0;
  logic        rst_b, start, mthi, mtlo, hilo_rd;
  logic [1:0]  op;
  logic [31:0] rs_val, rt_val, hi, lo;
  logic        busy, done, stall;

  int checks = 0;
  int errors = 0;
  logic [63:0] sbq[$];

  mips_muldiv_ctrl dut (
    .clk(clk), .rst_b(rst_b), .start(start), .op(op), .rs_val(rs_val), .rt_val(rt_val),
    .mthi(mthi), .mtlo(mtlo), .hilo_rd(hilo_rd), .hi(hi), .lo(lo),
    .busy(busy), .done(done), .stall(stall)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    if (o[0]) begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end else begin
      sa = longint'($signed(a));
      sb = longint'($signed(b));
    end
    if (!o[1]) begin
      res = 64'(sa * sb);
    end else if (b == 32'd0) begin
      res = {a, 32'hFFFF_FFFF};
    end else begin
      q = sa / sb;
      r = sa % sb;
      res = {r[31:0], q[31:0]};
    end
    return res;
  endfunction

  // Entered and left at a falling edge; the rising edge in between is T0.
  task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                       input logic [63:0] exp);
    op = o; rs_val = a; rt_val = b; start = 1'b1;
    sbq.push_back(exp);
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, input int n0);
    int n;
    logic [63:0] e;
    n = n0;
    while (done !== 1'b1 && n < 60) begin
      @(posedge clk); @(negedge clk); n++;
    end
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL %s done timeout: done=%b after %0d cycles, required 1", name, done, n);
      sbq.delete();
    end else if (sbq.size() == 0) begin
      errors++;
      $display("FAIL %s unexpected done: no pending op, required none", name);
    end else begin
      e = sbq.pop_front();
      checks++;
      if (hi !== e[63:32]) begin
        errors++; $display("FAIL %s hi: got %h required %h", name, hi, e[63:32]);
      end
      checks++;
      if (lo !== e[31:0]) begin
        errors++; $display("FAIL %s lo: got %h required %h", name, lo, e[31:0]);
      end
      checks++;
      if (n != 34) begin
        errors++; $display("FAIL %s latency: got %0d required 34", name, n);
      end
    end
  endtask

  task automatic test_reset();
    rst_b = 1'b0; start = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0;
    op = 2'd0; rs_val = '0; rt_val = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({hi, lo, busy, done, stall} !== 67'd0) begin
      errors++;
      $display("FAIL reset_state: hi=%h lo=%h busy=%b done=%b stall=%b required all 0", hi, lo, busy, done, stall);
    end
    rst_b = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_multu_max();
    issue(2'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'hFFFF_FFFE, 32'h0000_0001});
    checks++;
    if (busy !== 1'b1) begin
      errors++; $display("FAIL busy_after_start: got %b required 1", busy);
    end
    wait_done("multu_max", 1);
  endtask

  task automatic test_signed_cases();
    issue(2'd0, 32'hFFFF_FFFD, 32'd5, {32'hFFFF_FFFF, 32'hFFFF_FFF1});
    wait_done("mult_m3x5", 1);
    issue(2'd2, 32'hFFFF_FFF9, 32'd2, {32'hFFFF_FFFF, 32'hFFFF_FFFD});
    wait_done("div_m7d2", 1);
    issue(2'd2, 32'h8000_0000, 32'hFFFF_FFFF, {32'h0000_0000, 32'h8000_0000});
    wait_done("div_ovf", 1);
    issue(2'd3, 32'd9, 32'd0, {32'd9, 32'hFFFF_FFFF});
    wait_done("divu_zero", 1);
    issue(2'd2, 32'hFFFF_FFF0, 32'd0, {32'hFFFF_FFF0, 32'hFFFF_FFFF});
    wait_done("div_zero_neg", 1);
  endtask

  task automatic test_random();
    logic [1:0]  o;
    logic [31:0] a, b;
    for (int i = 0; i < 8; i++) begin
      o = 2'(i % 4);
      a = $urandom;
      b = (i == 6) ? 32'd0 : ((i % 3 == 0) ? $urandom_range(1, 100) : $urandom);
      issue(o, a, b, model(o, a, b));
      wait_done($sformatf("random%0d", i), 1);
    end
  endtask

  task automatic test_mthi_mtlo();
    mthi = 1'b1; rs_val = 32'h1234_5678;
    @(posedge clk); @(negedge clk);
    mthi = 1'b0; mtlo = 1'b1; rs_val = 32'hCAFE_F00D;
    @(posedge clk); @(negedge clk);
    mtlo = 1'b0;
    checks++;
    if ({hi, lo} !== {32'h1234_5678, 32'hCAFE_F00D}) begin
      errors++; $display("FAIL mthi_mtlo: got %h_%h required 12345678_cafef00d", hi, lo);
    end
    mthi = 1'b1;
    issue(2'd1, 32'd2, 32'd3, {32'd0, 32'd6});
    mthi = 1'b0;
    checks++;
    if (hi !== 32'h1234_5678) begin
      errors++; $display("FAIL start_beats_mthi: hi=%h required 12345678", hi);
    end
    wait_done("start_with_mthi", 1);
  endtask

  task automatic test_hazards();
    logic [31:0] h0, l0;
    h0 = hi; l0 = lo;
    issue(2'd1, 32'd7, 32'd6, {32'd0, 32'd42});
    for (int k = 0; k < 4; k++) begin
      start   = (k == 0);
      mthi    = (k == 1);
      mtlo    = (k == 2);
      hilo_rd = (k == 3);
      op = 2'd0; rs_val = 32'hDEAD_BEEF; rt_val = 32'd3;
      #1;
      checks++;
      if (stall !== 1'b1) begin
        errors++; $display("FAIL hazard%0d stall: got %b required 1", k, stall);
      end
      @(posedge clk); @(negedge clk);
      checks++;
      if ({hi, lo} !== {h0, l0}) begin
        errors++; $display("FAIL hazard%0d hilo_held: got %h_%h required %h_%h", k, hi, lo, h0, l0);
      end
    end
    start = 1'b0; mthi = 1'b0; mtlo = 1'b0; hilo_rd = 1'b0;
    wait_done("hazard_op", 5);
    hilo_rd = 1'b1;
    #1;
    checks++;
    if (stall !== 1'b0) begin
      errors++; $display("FAIL done_cycle_read stall: got %b required 0", stall);
    end
    hilo_rd = 1'b0;
  endtask

  task automatic test_back_to_back();
    issue(2'd3, 32'd100, 32'd7, {32'd2, 32'd14});
    wait_done("b2b_first", 1);
    issue(2'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, {32'd0, 32'd1});
    wait_done("b2b_second", 1);
  endtask

  task automatic test_reset_mid();
    bit seen;
    issue(2'd1, 32'd11, 32'd13, 64'd143);
    repeat (10) @(negedge clk);
    #2 rst_b = 1'b0;
    #1;
    checks++;
    if ({hi, lo, busy, done} !== 66'd0) begin
      errors++; $display("FAIL reset_mid: hi=%h lo=%h busy=%b done=%b required all 0", hi, lo, busy, done);
    end
    sbq.delete();
    @(negedge clk);
    rst_b = 1'b1;
    seen = 1'b0;
    repeat (40) begin
      @(posedge clk); @(negedge clk);
      if (done === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      errors++; $display("FAIL reset_abort: activity after reset seen=1 required 0");
    end
  endtask

  initial begin
    test_reset();
    test_multu_max();
    test_signed_cases();
    test_mthi_mtlo();
    test_hazards();
    test_back_to_back();
    test_random();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
